// File: rtl/zbin_to_z_pkg.sv
// zbin_to_z_pkg
// Shared constants and helpers for the z <-> zbin conversion blocks.
// Track z is 12-bit sign-magnitude: bit 11 = sign (1 = negative),
// bits 10:0 = magnitude, full scale 15 cm = 2047 counts.
// The forward z-to-zbin encoder uses the same thresholds from here.
package zbin_to_z_pkg;

    localparam logic [10:0] Z5  = 11'd683;
    localparam logic [10:0] Z10 = 11'd1365;
    localparam logic [10:0] Z15 = 11'd2047;

    localparam logic [3:0] ZBIN_NONE = 4'hF;
    localparam logic [3:0] NUM_ZBINS = 4'd5;

    typedef enum logic [1:0] {
        ZCLS_LEGAL,
        ZCLS_NONE,
        ZCLS_ILLEGAL
    } zbin_class_t;

    // Zero magnitude is always packed as positive zero.
    function automatic logic [11:0] sm_pack(input logic neg, input logic [10:0] mag);
        return {neg && (mag != '0), mag};
    endfunction

    function automatic zbin_class_t zbin_classify(input logic [3:0] zbin);
        if (zbin < NUM_ZBINS)
            return ZCLS_LEGAL;
        else if (zbin == ZBIN_NONE)
            return ZCLS_NONE;
        else
            return ZCLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/zbin_decode_lut.sv
// zbin_decode_lut
// Purely combinational map from a z-bin index to its z window.
// Ports:
//   zbin      in   4   bin index (0-4 legal, 15 none, 5-14 illegal)
//   z_lo      out  12  lower window edge, sign-magnitude
//   z_hi      out  12  upper window edge, sign-magnitude
//   z_center  out  12  window centre, sign-magnitude
//   none      out  1   zbin was 15; z outputs are 0
//   err       out  1   zbin was 5-14; z outputs are 0
module zbin_decode_lut
    import zbin_to_z_pkg::*;
(
    input  logic [3:0]  zbin,
    output logic [11:0] z_lo,
    output logic [11:0] z_hi,
    output logic [11:0] z_center,
    output logic        none,
    output logic        err
);

    always_comb begin
        z_lo     = '0;
        z_hi     = '0;
        z_center = '0;
        none     = 1'b0;
        err      = 1'b0;
        case (zbin)
            4'd0: begin
                z_lo     = sm_pack(1'b1, Z15);
                z_hi     = sm_pack(1'b1, Z5);
                z_center = sm_pack(1'b1, Z10);
            end
            4'd1: begin
                z_lo     = sm_pack(1'b1, Z10);
                z_hi     = '0;
                z_center = sm_pack(1'b1, Z5);
            end
            4'd2: begin
                z_lo     = sm_pack(1'b1, Z5);
                z_hi     = sm_pack(1'b0, Z5);
                z_center = '0;
            end
            4'd3: begin
                z_lo     = '0;
                z_hi     = sm_pack(1'b0, Z10);
                z_center = sm_pack(1'b0, Z5);
            end
            4'd4: begin
                z_lo     = sm_pack(1'b0, Z5);
                z_hi     = sm_pack(1'b0, Z15);
                z_center = sm_pack(1'b0, Z10);
            end
            ZBIN_NONE: none = 1'b1;
            default:   err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/zbin_to_z.sv
// zbin_to_z
// Two-stage valid/ready decoder from jet-finder z-bin index to a z window.
// Stage 1 holds the accepted zbin; stage 2 holds the decoded window and flags.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid/in_ready/zbin    input handshake and bin index
//   out_valid/out_ready       output handshake
//   z_lo, z_hi, z_center      decoded window (sign-magnitude)
//   out_none, out_err         bin was 15 / bin was 5-14
//   err_cnt                   saturating count of illegal codes accepted
module zbin_to_z
    import zbin_to_z_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       zbin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      z_lo,
    output logic [11:0]      z_hi,
    output logic [11:0]      z_center,
    output logic             out_none,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic        s1_valid;
    logic [3:0]  s1_zbin;
    logic        s2_valid;
    logic        s2_load;
    logic        in_fire;
    logic [11:0] d_lo, d_hi, d_center;
    logic        d_none, d_err;

    zbin_decode_lut u_lut (
        .zbin     (s1_zbin),
        .z_lo     (d_lo),
        .z_hi     (d_hi),
        .z_center (d_center),
        .none     (d_none),
        .err      (d_err)
    );

    // in_ready looks through to out_ready so a full pipeline still streams
    // one item per cycle; it is also forced low while reset is asserted.
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = reset_n && (!s1_valid || s2_load);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_zbin  <= '0;
            s2_valid <= 1'b0;
            z_lo     <= '0;
            z_hi     <= '0;
            z_center <= '0;
            out_none <= 1'b0;
            out_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_zbin  <= zbin;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2_valid <= 1'b1;
                z_lo     <= d_lo;
                z_hi     <= d_hi;
                z_center <= d_center;
                out_none <= d_none;
                out_err  <= d_err;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end

            if (in_fire && (zbin_classify(zbin) == ZCLS_ILLEGAL) && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_zbin_to_z.sv
// tb_zbin_to_z
// Scoreboard bench for zbin_to_z: the driver pushes hand-written expected
// windows on each accepted input, a monitor pops and compares on each
// output transfer and checks that held outputs stay stable.
module tb_zbin_to_z;

    typedef struct {
        logic [11:0] lo;
        logic [11:0] hi;
        logic [11:0] c;
        logic        none;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  zbin = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] z_lo, z_hi, z_center;
    logic        out_none, out_err;
    logic [15:0] err_cnt;

    // Narrow-counter instance used to reach saturation quickly.
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [3:0]  s_zbin = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [11:0] s_z_lo, s_z_hi, s_z_center;
    logic        s_out_none, s_out_err;
    logic [1:0]  s_err_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   exp_err  = 0;
    exp_t sb[$];
    exp_t held;
    bit   have_held = 1'b0;
    bit   rnd_en    = 1'b0;

    always #5 clk = ~clk;

    zbin_to_z #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .zbin(zbin),
        .out_valid(out_valid), .out_ready(out_ready),
        .z_lo(z_lo), .z_hi(z_hi), .z_center(z_center),
        .out_none(out_none), .out_err(out_err), .err_cnt(err_cnt)
    );

    zbin_to_z #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .zbin(s_zbin),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .z_lo(s_z_lo), .z_hi(s_z_hi), .z_center(s_z_center),
        .out_none(s_out_none), .out_err(s_out_err), .err_cnt(s_err_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Hand-computed windows: Z5=0x2AB, Z10=0x555, Z15=0x7FF, negative adds 0x800.
    function automatic exp_t model(input logic [3:0] b);
        exp_t r;
        case (b)
            4'd0:    r = '{12'hFFF, 12'hAAB, 12'hD55, 1'b0, 1'b0};
            4'd1:    r = '{12'hD55, 12'h000, 12'hAAB, 1'b0, 1'b0};
            4'd2:    r = '{12'hAAB, 12'h2AB, 12'h000, 1'b0, 1'b0};
            4'd3:    r = '{12'h000, 12'h555, 12'h2AB, 1'b0, 1'b0};
            4'd4:    r = '{12'h2AB, 12'h7FF, 12'h555, 1'b0, 1'b0};
            4'd15:   r = '{12'h000, 12'h000, 12'h000, 1'b1, 1'b0};
            default: r = '{12'h000, 12'h000, 12'h000, 1'b0, 1'b1};
        endcase
        return r;
    endfunction

    function automatic logic [37:0] pack_exp(input exp_t e);
        return {e.lo, e.hi, e.c, e.none, e.err};
    endfunction

    // Monitor
    always @(negedge clk) begin
        logic [37:0] cur;
        exp_t e;
        cur = {z_lo, z_hi, z_center, out_none, out_err};
        if (reset_n && out_valid) begin
            if (have_held)
                check("hold_stable", cur, pack_exp(held));
            if (out_ready) begin
                have_held = 1'b0;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0h, expected no output", cur);
                end else begin
                    e = sb.pop_front();
                    check("out_window", cur, pack_exp(e));
                    n_out++;
                end
            end else begin
                held = '{z_lo, z_hi, z_center, out_none, out_err};
                have_held = 1'b1;
            end
        end else begin
            have_held = 1'b0;
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] b);
        int  budget;
        bit  ok;
        budget = 200;
        ok = 1'b0;
        in_valid = 1'b1;
        zbin = b;
        while (!ok && budget > 0) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else budget--;
        end
        if (ok) begin
            sb.push_back(model(b));
            if (b >= 4'd5 && b <= 4'd14) exp_err++;
        end else begin
            timeout_fail("send_accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 5000;
        while ((sb.size() != 0 || out_valid) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timeout_fail(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int idx;
        int out_before;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_err_cnt", err_cnt, 0);
        check("reset_z", {z_lo, z_hi, z_center, out_none, out_err}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Streaming, all legal bins back-to-back
        for (int b = 0; b < 5; b++) send(4'(b));
        drain("drain_stream");
        check("stream_count", n_out, 5);
        check("err_cnt_stream", err_cnt, 0);

        // No-bin code
        send(4'hF);
        drain("drain_none");
        check("err_cnt_none", err_cnt, 0);

        // Illegal codes
        send(4'd5);
        send(4'd9);
        send(4'd14);
        drain("drain_illegal");
        check("err_cnt_illegal", err_cnt, 3);

        // Backpressure: 6 cycles with out_ready low, input held valid
        out_ready = 1'b0;
        acc = 0;
        idx = 0;
        in_valid = 1'b1;
        zbin = 4'd1;
        repeat (6) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(zbin));
                acc++;
                idx++;
            end
            @(posedge clk);
            #1;
            zbin = idx[0] ? 4'd3 : 4'd1;
        end
        @(negedge clk);
        check("bp_accepted", acc, 2);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid_held", out_valid, 1);
        @(posedge clk);
        #1;
        out_before = n_out;
        out_ready = 1'b1;
        send(zbin);
        drain("drain_bp");
        check("bp_out_count", n_out - out_before, 3);

        // Random out_ready with random codes
        rnd_en = 1'b1;
        fork
            begin
                while (rnd_en) begin
                    @(posedge clk);
                    #1;
                    if (rnd_en) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            send(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("drain_random");
        check("err_cnt_random", err_cnt, exp_err);

        // Reset with the pipeline full
        out_ready = 1'b0;
        send(4'd2);
        send(4'd4);
        @(negedge clk);
        check("full_before_reset", in_ready, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        exp_err = 0;
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        check("post_reset_out_valid", out_valid, 0);
        check("post_reset_err_cnt", err_cnt, 0);
        in_valid = 1'b1;
        zbin = 4'd3;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        if (in_ready) sb.push_back(model(4'd3));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_cycle1", out_valid, 0);
        @(negedge clk);
        check("latency_cycle2", out_valid, 1);
        drain("drain_reset");
        check("err_cnt_after_reset", err_cnt, exp_err);

        // Saturation on the 2-bit counter instance
        for (int k = 1; k <= 5; k++) begin
            s_in_valid = 1'b1;
            s_zbin = 4'(4 + k);
            @(negedge clk);
            check("sat_in_ready", s_in_ready, 1);
            @(posedge clk);
            #1;
            check("sat_err_cnt", s_err_cnt, (k > 3) ? 3 : k);
        end
        s_in_valid = 1'b0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
